// File: rtl/laundry_req_scheduler.sv
// Laundry request scheduler: captures per-floor call presses, removes
// duplicates, queues them in arrival order and presents the oldest as a
// one-hot request until the controller reports it served.
module laundry_req_scheduler #(
   parameter int N_FLOORS = 4,
   parameter int IDX_W    = $clog2(N_FLOORS),
   parameter int CNT_W    = $clog2(N_FLOORS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] btn,
   input  logic                wash_done,
   output logic [N_FLOORS-1:0] req_laundry,
   output logic                req_valid,
   output logic [N_FLOORS-1:0] pending,
   output logic [CNT_W-1:0]    count,
   output logic                spurious_done
);

   // queue state
   logic [IDX_W-1:0]    fifo [N_FLOORS];
   logic [IDX_W-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0]    cnt;
   logic [N_FLOORS-1:0] qmask, cap;

   // next-state terms
   logic                pop, push;
   logic [IDX_W-1:0]    push_idx;
   logic [N_FLOORS-1:0] qmask_pop, new_req, cand, push_oh;
   logic [N_FLOORS-1:0] qmask_nxt, cap_nxt;
   logic [IDX_W-1:0]    rd_nxt, wr_nxt;
   logic [CNT_W-1:0]    cnt_nxt;

   // Pointer increment with explicit wrap so non-power-of-two depths work.
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      if (p == IDX_W'(N_FLOORS - 1)) return '0;
      return p + IDX_W'(1);
   endfunction

   // Pop first, then accept new presses against the post-pop mask, then
   // enqueue the lowest-index candidate.
   always_comb begin
      pop       = wash_done && (cnt != '0);
      qmask_pop = qmask;
      if (pop) qmask_pop[fifo[rd_ptr]] = 1'b0;
      new_req   = btn & ~cap & ~qmask_pop;
      cand      = cap | new_req;
      push      = |cand;
      push_idx  = '0;
      for (int i = N_FLOORS - 1; i >= 0; i--)
         if (cand[i]) push_idx = IDX_W'(i);
      push_oh   = push ? (N_FLOORS'(1) << push_idx) : '0;
      cap_nxt   = cand & ~push_oh;
      qmask_nxt = qmask_pop | push_oh;
      rd_nxt    = pop  ? ptr_inc(rd_ptr) : rd_ptr;
      wr_nxt    = push ? ptr_inc(wr_ptr) : wr_ptr;
      cnt_nxt   = cnt + CNT_W'(push) - CNT_W'(pop);
   end

   // Queue control state; reset discards everything queued or captured.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         qmask  <= '0;
         cap    <= '0;
      end else begin
         rd_ptr <= rd_nxt;
         wr_ptr <= wr_nxt;
         cnt    <= cnt_nxt;
         qmask  <= qmask_nxt;
         cap    <= cap_nxt;
      end
   end

   // FIFO payload; contents are don't-care until the occupancy covers them.
   always_ff @(posedge clk) begin
      if (!reset && push) fifo[wr_ptr] <= push_idx;
   end

   // Registered outputs derived from the current queue state.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_laundry   <= '0;
         req_valid     <= 1'b0;
         pending       <= '0;
         count         <= '0;
         spurious_done <= 1'b0;
      end else begin
         req_laundry   <= (cnt != '0) ? (N_FLOORS'(1) << fifo[rd_ptr]) : '0;
         req_valid     <= (cnt != '0);
         pending       <= qmask | cap;
         count         <= cnt;
         spurious_done <= wash_done && (cnt == '0);
      end
   end

endmodule

// File: tb/tb_laundry_req_scheduler.sv
// Directed bench for laundry_req_scheduler with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
module tb_laundry_req_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn;
   logic       wash_done;
   logic [3:0] req_laundry;
   logic       req_valid;
   logic [3:0] pending;
   logic [2:0] count;
   logic       spurious_done;

   int checks = 0;
   int errors = 0;

   laundry_req_scheduler #(.N_FLOORS(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .btn           (btn),
      .wash_done     (wash_done),
      .req_laundry   (req_laundry),
      .req_valid     (req_valid),
      .pending       (pending),
      .count         (count),
      .spurious_done (spurious_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input logic [3:0] rq, input logic [3:0] pd, input logic [2:0] ct);
      chk({tag, ".req"},   32'(req_laundry), 32'(rq));
      chk({tag, ".vld"},   32'(req_valid),   32'(rq != 4'b0));
      chk({tag, ".pend"},  32'(pending),     32'(pd));
      chk({tag, ".count"}, 32'(count),       32'(ct));
   endtask

   // one-cycle wash_done pulse, then one more edge so outputs show the result
   task automatic serve();
      wash_done = 1'b1; tick();
      wash_done = 1'b0; tick();
   endtask

   initial begin
      reset = 1'b1; btn = 4'b1111; wash_done = 1'b1;
      tick(); tick();
      outs("rst", 4'b0, 4'b0, 3'd0);
      chk("rst.spur", 32'(spurious_done), 32'd0);
      reset = 1'b0; btn = 4'b0; wash_done = 1'b0;
      tick(); tick();
      outs("post_rst", 4'b0, 4'b0, 3'd0);

      // single request and service
      btn = 4'b0100; tick();
      btn = 4'b0;    tick();
      outs("single", 4'b0100, 4'b0100, 3'd1);
      wash_done = 1'b1; tick();
      chk("single.hold", 32'(req_laundry), 32'h4);
      chk("single.nospur", 32'(spurious_done), 32'd0);
      wash_done = 1'b0; tick();
      outs("single.done", 4'b0, 4'b0, 3'd0);

      // simultaneous presses: lowest index first, one push per cycle
      btn = 4'b1100; tick();
      btn = 4'b0;    tick();
      outs("simul.a", 4'b0100, 4'b1100, 3'd1);
      tick();
      outs("simul.b", 4'b0100, 4'b1100, 3'd2);
      serve();
      outs("simul.c", 4'b1000, 4'b1000, 3'd1);
      serve();
      outs("simul.d", 4'b0, 4'b0, 3'd0);

      // duplicate press of a queued floor is dropped
      btn = 4'b1000; tick();
      btn = 4'b0;    tick();
      btn = 4'b0001; tick();
      btn = 4'b1000; tick();
      btn = 4'b0;    tick();
      outs("dup", 4'b1000, 4'b1001, 3'd2);
      serve();
      outs("dup.b", 4'b0001, 4'b0001, 3'd1);
      serve();
      outs("dup.c", 4'b0, 4'b0, 3'd0);

      // full queue (1,0,2,3), head re-pressed while being served
      btn = 4'b0010; tick();
      btn = 4'b1101; tick();
      btn = 4'b0;    tick(); tick(); tick();
      outs("full", 4'b0010, 4'b1111, 3'd4);
      wash_done = 1'b1; btn = 4'b0010; tick();
      wash_done = 1'b0; btn = 4'b0;    tick();
      outs("repress", 4'b0001, 4'b1111, 3'd4);
      serve(); outs("drain.a", 4'b0100, 4'b1110, 3'd3);
      serve(); outs("drain.b", 4'b1000, 4'b1010, 3'd2);
      serve(); outs("drain.c", 4'b0010, 4'b0010, 3'd1);
      serve(); outs("drain.d", 4'b0,    4'b0,    3'd0);

      // fill all, serve all, refill 2 then 0 across the pointer wrap
      btn = 4'b1111; tick();
      btn = 4'b0;    tick(); tick(); tick(); tick();
      outs("fill", 4'b0001, 4'b1111, 3'd4);
      serve(); chk("fill.h1", 32'(req_laundry), 32'h2);
      serve(); chk("fill.h2", 32'(req_laundry), 32'h4);
      serve(); chk("fill.h3", 32'(req_laundry), 32'h8);
      serve(); outs("fill.empty", 4'b0, 4'b0, 3'd0);
      btn = 4'b0100; tick();
      btn = 4'b0001; tick();
      btn = 4'b0;    tick();
      outs("wrap", 4'b0100, 4'b0101, 3'd2);
      serve(); outs("wrap.b", 4'b0001, 4'b0001, 3'd1);
      serve(); outs("wrap.c", 4'b0, 4'b0, 3'd0);

      // wash_done on empty queue: one-cycle spurious pulse
      wash_done = 1'b1; tick();
      chk("spur.on", 32'(spurious_done), 32'd1);
      chk("spur.cnt", 32'(count), 32'd0);
      wash_done = 1'b0; tick();
      chk("spur.off", 32'(spurious_done), 32'd0);
      outs("spur.q", 4'b0, 4'b0, 3'd0);

      // reset mid-operation discards three queued entries
      btn = 4'b0111; tick();
      btn = 4'b0;    tick(); tick(); tick();
      outs("pre_rst", 4'b0001, 4'b0111, 3'd3);
      reset = 1'b1; tick();
      outs("mid_rst", 4'b0, 4'b0, 3'd0);
      reset = 1'b0; tick(); tick();
      outs("after_rst", 4'b0, 4'b0, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule
